// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: types and constants shared by the March C- BIST initiator
// and its compare pipeline.
//   bist_state_e  : controller states
//   march_elem_e  : march element index M0..M5
//   ELEM_* masks  : per-element properties, bit index = element index
//   ERR_W         : width of the saturating mismatch counter
package ram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } march_elem_e;

  localparam int ERR_W = 16;

  // M3..M5 walk the address space downwards.
  localparam logic [5:0] ELEM_DOWN   = 6'b111000;
  // M1..M5 start each address with a read.
  localparam logic [5:0] ELEM_HAS_RD = 6'b111110;
  // M0..M4 write each address (after the read when there is one).
  localparam logic [5:0] ELEM_HAS_WR = 6'b011111;
  // Reads of M2 and M4 expect ~P; the others expect P.
  localparam logic [5:0] ELEM_RD_INV = 6'b010100;
  // Writes of M1 and M3 store ~P; the others store P.
  localparam logic [5:0] ELEM_WR_INV = 6'b001010;

  function automatic march_elem_e elem_next(input march_elem_e e);
    return march_elem_e'(e + 3'd1);
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: read-data compare pipeline for the RAM BIST.
// Each issued read enters an RD_LAT-deep shift register carrying its
// expected word and address; the tail lines up with the RAM's data_out.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_clear             clears counters and flushes pipeline (new run)
//   i_push              a read is on the RAM command port this cycle
//   i_exp, i_addr       expected data / address of that read
//   i_rdata             RAM read data
//   o_mismatch          tail compare failed this cycle
//   o_err_count         saturating mismatch count
//   o_first_fail_addr   address of the first mismatch of the run
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_mismatch,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [ADDR_W-1:0] o_first_fail_addr
);

  logic              r_vld_p  [RD_LAT];
  logic [DATA_W-1:0] r_exp_p  [RD_LAT];
  logic [ADDR_W-1:0] r_addr_p [RD_LAT];
  logic [ERR_W-1:0]  r_err_count;
  logic [ADDR_W-1:0] r_first_fail_addr;
  logic              w_mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage boundary: issued read -> RD_LAT-deep tag pipeline.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      for (int i = 0; i < RD_LAT; i++) r_vld_p[i] <= 1'b0;
    end else begin
      r_vld_p[0] <= i_push;
      for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_exp_p[0]  <= i_exp;
    r_addr_p[0] <= i_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      r_exp_p[i]  <= r_exp_p[i-1];
      r_addr_p[i] <= r_addr_p[i-1];
    end
  end

  assign w_mismatch = r_vld_p[RD_LAT-1] && (i_rdata != r_exp_p[RD_LAT-1]);

  // Stage boundary: tail compare -> error counter / first-fail capture.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_err_count       <= '0;
      r_first_fail_addr <= '0;
    end else if (w_mismatch) begin
      r_err_count <= sat_inc(r_err_count);
      if (r_err_count == '0) r_first_fail_addr <= r_addr_p[RD_LAT-1];
    end
  end

  assign o_mismatch        = w_mismatch;
  assign o_err_count       = r_err_count;
  assign o_first_fail_addr = r_first_fail_addr;

endmodule

// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- built-in self-test initiator for a single-clock
// RAM with a write port, a read port and RD_LAT cycles of read latency.
// Sequence (P = background pattern captured at start):
//   M0 up: w P | M1 up: r P, w ~P | M2 up: r ~P, w P
//   M3 down: r P, w ~P | M4 down: r ~P, w P | M5 down: r P
// One command per cycle, 10*DEPTH RUN cycles, then RD_LAT DRAIN cycles.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, pattern             run request / background pattern
//   busy, done, pass           run status
//   err_count, first_fail_addr mismatch statistics
//   write, wr_address, data_in RAM write command (registered)
//   read, rd_address           RAM read command (registered)
//   data_out                   RAM read data
// Optional build macro RAM_BIST_STOP_ON_FAIL_EN: stop issuing commands on
// the first mismatch, drain the in-flight reads, then report DONE.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              write,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] data_in,
  output logic              read,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [DATA_W-1:0] data_out
);

  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);
  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DCW-1:0] D_LAST = DCW'(RD_LAT - 1);

  bist_state_e       r_state;
  bist_state_e       w_state_nxt;
  march_elem_e       r_elem;
  logic [ADDR_W-1:0] r_addr;
  logic              r_phase;       // 1: current op is a write, 0: a read
  logic [DATA_W-1:0] r_pat;
  logic [DCW-1:0]    r_drain_cnt;
  logic              r_write;
  logic              r_read;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_data_in;
  logic [DATA_W-1:0] r_rd_exp;

  march_elem_e       w_nxt_elem;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic              w_nxt_phase;
  logic              w_seq_end;
  logic              w_at_end;

  logic              w_start_acc;
  march_elem_e       w_iss_elem;
  logic [ADDR_W-1:0] w_iss_addr;
  logic              w_iss_phase;
  logic              w_iss_wr;
  logic              w_iss_rd;
  logic [DATA_W-1:0] w_iss_base;
  logic [DATA_W-1:0] w_iss_wdata;
  logic [DATA_W-1:0] w_iss_exp;

  logic              w_mismatch;
  logic              w_stop;
  logic [ERR_W-1:0]  w_err_count;
  logic [ADDR_W-1:0] w_first_fail_addr;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  logic w_unused_mismatch;
  assign w_unused_mismatch = w_mismatch;
  assign w_stop = 1'b0;
`endif

  // Terminal compare against DEPTH-1 / 0 so the element wrap never relies
  // on ADDR_W overflow (DEPTH may equal 2**ADDR_W).
  assign w_at_end = ELEM_DOWN[r_elem] ? (r_addr == '0) : (r_addr == A_LAST);

  // Position after the current operation.
  always_comb begin
    w_nxt_elem  = r_elem;
    w_nxt_addr  = r_addr;
    w_nxt_phase = r_phase;
    w_seq_end   = 1'b0;
    if (!r_phase && ELEM_HAS_WR[r_elem]) begin
      w_nxt_phase = 1'b1;
    end else if (!w_at_end) begin
      w_nxt_addr  = ELEM_DOWN[r_elem] ? r_addr - 1'b1 : r_addr + 1'b1;
      w_nxt_phase = !ELEM_HAS_RD[r_elem];
    end else if (r_elem == M5) begin
      w_seq_end = 1'b1;
    end else begin
      w_nxt_elem  = elem_next(r_elem);
      w_nxt_addr  = ELEM_DOWN[w_nxt_elem] ? A_LAST : '0;
      w_nxt_phase = !ELEM_HAS_RD[w_nxt_elem];
    end
  end

  // Next state and the command to register for the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_iss_elem  = r_elem;
    w_iss_addr  = r_addr;
    w_iss_phase = r_phase;
    w_iss_wr    = 1'b0;
    w_iss_rd    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_start_acc = 1'b1;
          w_iss_elem  = M0;
          w_iss_addr  = '0;
          w_iss_phase = 1'b1;
        end
      end
      RUN: begin
        if (w_seq_end || w_stop) begin
          w_state_nxt = DRAIN;
        end else begin
          w_iss_elem  = w_nxt_elem;
          w_iss_addr  = w_nxt_addr;
          w_iss_phase = w_nxt_phase;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == D_LAST) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == RUN) begin
      w_iss_wr = w_iss_phase;
      w_iss_rd = !w_iss_phase;
    end
  end

  assign w_iss_base  = w_start_acc ? pattern : r_pat;
  assign w_iss_wdata = w_iss_base ^ {DATA_W{ELEM_WR_INV[w_iss_elem]}};
  assign w_iss_exp   = w_iss_base ^ {DATA_W{ELEM_RD_INV[w_iss_elem]}};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Stage boundary: issue decision -> registered RAM command port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_elem      <= M0;
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_pat       <= '0;
      r_drain_cnt <= '0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_data_in   <= '0;
      r_rd_exp    <= '0;
    end else begin
      r_write <= w_iss_wr;
      r_read  <= w_iss_rd;
      if (w_start_acc) r_pat <= pattern;
      if (w_iss_wr || w_iss_rd) begin
        r_elem  <= w_iss_elem;
        r_addr  <= w_iss_addr;
        r_phase <= w_iss_phase;
      end
      if (w_iss_wr) begin
        r_wr_addr <= w_iss_addr;
        r_data_in <= w_iss_wdata;
      end
      if (w_iss_rd) begin
        r_rd_addr <= w_iss_addr;
        r_rd_exp  <= w_iss_exp;
      end
      if (r_state == DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                  r_drain_cnt <= '0;
    end
  end

  ram_bist_cmp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk               (clk),
    .reset             (reset),
    .i_clear           (w_start_acc),
    .i_push            (r_read),
    .i_exp             (r_rd_exp),
    .i_addr            (r_rd_addr),
    .i_rdata           (data_out),
    .o_mismatch        (w_mismatch),
    .o_err_count       (w_err_count),
    .o_first_fail_addr (w_first_fail_addr)
  );

  assign busy            = (r_state == RUN) || (r_state == DRAIN);
  assign done            = (r_state == DONE);
  assign pass            = done && (w_err_count == '0);
  assign err_count       = w_err_count;
  assign first_fail_addr = w_first_fail_addr;
  assign write           = r_write;
  assign wr_address      = r_wr_addr;
  assign data_in         = r_data_in;
  assign read            = r_read;
  assign rd_address      = r_rd_addr;

endmodule

// File: tb/tb_ram_march_bist.sv
module tb_ram_march_bist;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 1;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  // Stop after the first failing read's following write slot.
  localparam int S2_ERR = 1, S2_WR = 38, S2_RD = 22, S2_BUSY = 61;
  localparam int S3_ERR = 1, S3_WR = 22, S3_RD = 6,  S3_BUSY = 29;
`else
  localparam int S2_ERR = 2, S2_WR = 80, S2_RD = 80, S2_BUSY = 161;
  localparam int S3_ERR = 3, S3_WR = 80, S3_RD = 80, S3_BUSY = 161;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] pattern;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_fail_addr;
  logic              write, read;
  logic [ADDR_W-1:0] wr_address, rd_address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  logic              fault_en;
  logic              cnt_clr;
  logic [DATA_W-1:0] mem [DEPTH];
  int                n_wr, n_rd, n_busy, n_both;
  int                n_tests, n_fail;
  int                cyc;

  ram_march_bist #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .pattern         (pattern),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr),
    .write           (write),
    .wr_address      (wr_address),
    .data_in         (data_in),
    .read            (read),
    .rd_address      (rd_address),
    .data_out        (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, read latency 1; optional bit 0 stuck-at-0 at address 5.
  always @(posedge clk) begin
    if (write)
      mem[wr_address] <= data_in & ~((fault_en && wr_address == 4'd5) ? 64'h1 : 64'h0);
    if (read)
      data_out <= mem[rd_address];
  end

  always @(posedge clk) begin
    if (cnt_clr) begin
      n_wr <= 0; n_rd <= 0; n_busy <= 0; n_both <= 0;
    end else begin
      if (write)         n_wr   <= n_wr + 1;
      if (read)          n_rd   <= n_rd + 1;
      if (busy)          n_busy <= n_busy + 1;
      if (write && read) n_both <= n_both + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [DATA_W-1:0] pat);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    start   = 1'b1;
    pattern = pat;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_on_start", err_count, 0);
    chk("done_cleared_on_start", done, 0);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    chk("done_within_bound", done, 1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; pattern = '0; fault_en = 1'b0; cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ffa", first_fail_addr, 0);
    chk("rst_write", write, 0);
    chk("rst_read", read, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Scenario 1: fault-free, P = 0.
    launch(64'h0);
    wait_done(cyc);
    chk("s1_cycles", cyc, 161);
    chk("s1_busy_cycles", n_busy, 161);
    chk("s1_pass", pass, 1);
    chk("s1_err", err_count, 0);
    chk("s1_ffa", first_fail_addr, 0);
    chk("s1_writes", n_wr, 80);
    chk("s1_reads", n_rd, 80);
    chk("s1_no_overlap", n_both, 0);
    repeat (5) @(negedge clk);
    chk("s1_done_sticky", done, 1);
    chk("s1_idle_write", write, 0);
    chk("s1_idle_read", read, 0);

    // Scenario 4: start re-pulsed mid-run with a different pattern.
    launch(64'h0);
    repeat (18) @(negedge clk);
    start = 1'b1;
    pattern = 64'hA5A5_A5A5_A5A5_A5A5;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("s4_busy_cycles", n_busy, 161);
    chk("s4_err", err_count, 0);
    chk("s4_pass", pass, 1);
    chk("s4_writes", n_wr, 80);

    // Scenario 2: address 5 bit 0 stuck-at-0, P = 0.
    fault_en = 1'b1;
    launch(64'h0);
    wait_done(cyc);
    chk("s2_err", err_count, S2_ERR);
    chk("s2_ffa", first_fail_addr, 5);
    chk("s2_pass", pass, 0);
    chk("s2_busy_cycles", n_busy, S2_BUSY);
    chk("s2_writes", n_wr, S2_WR);
    chk("s2_reads", n_rd, S2_RD);

    // Scenario 3: same fault, P = all ones.
    launch(64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(cyc);
    chk("s3_err", err_count, S3_ERR);
    chk("s3_ffa", first_fail_addr, 5);
    chk("s3_pass", pass, 0);
    chk("s3_busy_cycles", n_busy, S3_BUSY);
    chk("s3_writes", n_wr, S3_WR);
    chk("s3_reads", n_rd, S3_RD);

    // Scenario 5: reset mid-run aborts, fresh run passes.
    fault_en = 1'b0;
    launch(64'h0123_4567_89AB_CDEF);
    repeat (48) @(negedge clk);
    chk("s5_busy_before_reset", busy, 1);
    chk("s5_cmd_before_reset", write | read, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("s5_write_after_reset", write, 0);
    chk("s5_read_after_reset", read, 0);
    chk("s5_busy_after_reset", busy, 0);
    chk("s5_err_after_reset", err_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("s5_idle_cmd", write | read, 0);
    launch(64'h0123_4567_89AB_CDEF);
    wait_done(cyc);
    chk("s5_cycles", cyc, 161);
    chk("s5_pass", pass, 1);
    chk("s5_err", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
